// File: rtl/uart_rx_frame_pkg.sv
// rtl/uart_rx_frame_pkg.sv - shared UART receive types and baud divisor constants
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    // Divisors shared with speed_select (50 MHz / 9600 baud)
    localparam int BPS_9600       = 5207;
    localparam int BPS_9600_HALF  = 2603;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - received-byte valid/ready handshake towards the register block
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_frame_sync.sv
// rtl/uart_rx_frame_sync.sv - serial line synchronizer and falling-edge detector
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rs232_rx,
    output logic rx_s,
    output logic rx_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Flops reset to 1 so reset release never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rs232_rx};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rx_s    = r_sync[SYNC_STAGES-1];
    assign rx_fall = r_prev & ~r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receive framer: start detect, mid-bit sampling, byte delivery
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rs232_rx,
    input  logic           clk_bps,
    output logic           bps_start,
    output logic           frame_err,
    output logic           overrun,
    uart_rx_frame_if.master rx_if
);
    localparam int CW = $clog2(DATA_BITS + 1);

    uart_rx_state_e       r_state, w_next;
    logic [CW-1:0]        r_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_pend;
    logic                 r_bps;
    logic                 r_fe;
    logic                 r_ov;
    logic                 w_rx_s;
    logic                 w_rx_fall;
    logic                 w_stop_good;
    logic                 w_stop_bad;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .rs232_rx (rs232_rx),
        .rx_s     (w_rx_s),
        .rx_fall  (w_rx_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            IDLE:      if (w_rx_fall) w_next = START;
            START:     if (clk_bps) w_next = w_rx_s ? IDLE : DATA;
            DATA:      if (clk_bps && r_cnt == CW'(DATA_BITS - 1)) w_next = STOP;
            STOP: begin
                if (clk_bps) begin
                    if (w_rx_s) begin
                        w_next      = IDLE;
                        w_stop_good = 1'b1;
                    end else begin
                        w_next      = WAIT_IDLE;
                        w_stop_bad  = 1'b1;
                    end
                end
            end
            WAIT_IDLE: if (w_rx_s) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Good frames are delivered one cycle after the stop sample (r_pend)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_pend  <= 1'b0;
            r_bps   <= 1'b0;
            r_fe    <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            r_bps  <= (w_next == START) || (w_next == DATA) || (w_next == STOP);
            r_fe   <= w_stop_bad;
            r_pend <= w_stop_good;
            r_ov   <= 1'b0;
            if (r_state == START && clk_bps) begin
                r_cnt <= '0;
            end
            if (r_state == DATA && clk_bps) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                r_cnt   <= r_cnt + 1'b1;
            end
            if (r_pend) begin
                if (!r_valid || rx_if.rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ov <= 1'b1;
                end
            end else if (r_valid && rx_if.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bps_start       = r_bps;
    assign frame_err       = r_fe;
    assign overrun         = r_ov;
    assign rx_if.rx_data   = r_data;
    assign rx_if.rx_valid  = r_valid;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - self-checking bench for uart_rx_frame with a scaled baud model
module tb_uart_rx_frame;
    import uart_pkg::*;

    // Scaled-down bit period keeps the run short; HALF places samples mid-bit
    localparam int BIT  = 40;
    localparam int HALF = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rs232_rx = 1'b1;
    logic clk_bps;
    logic bps_start;
    logic frame_err;
    logic overrun;
    int   bps_cnt;

    int total = 0;
    int bad   = 0;

    int n_fe = 0, n_ov = 0, n_vcyc = 0, n_bps = 0, got_cnt = 0;
    logic [7:0] got_mem [256];

    uart_rx_frame_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_frame #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .rs232_rx  (rs232_rx),
        .clk_bps   (clk_bps),
        .bps_start (bps_start),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_if     (rx_if.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)                             bps_cnt <= 0;
        else if (!bps_start || bps_cnt == BIT - 1) bps_cnt <= 0;
        else                                 bps_cnt <= bps_cnt + 1;
    end
    assign clk_bps = bps_start && (bps_cnt == HALF);

    always @(negedge clk) begin
        n_fe   <= n_fe + int'(frame_err);
        n_ov   <= n_ov + int'(overrun);
        n_vcyc <= n_vcyc + int'(rx_if.rx_valid);
        n_bps  <= n_bps + int'(bps_start);
        if (rx_if.rx_valid && rx_if.rx_ready) begin
            got_mem[got_cnt % 256] <= rx_if.rx_data;
            got_cnt <= got_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rs232_rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            tick(BIT);
        end
        rs232_rx = stop;
        tick(BIT);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_if.rx_ready = 1'b1;
        tick(3);
        total++; if (bps_start !== 1'b0) begin bad++; $display("FAIL reset_bps got=%b want=0", bps_start); end
        total++; if (rx_if.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rx_if.rx_data); end
        total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rx_if.rx_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b want=0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b want=0", overrun); end
        rst = 1'b0;
        tick(BIT);
    endtask

    task automatic test_single;
        int g0, v0, f0, pulses, lat, k;
        logic bps_after;
        g0 = got_cnt; v0 = n_vcyc; f0 = n_fe;
        pulses = 0; lat = -1; bps_after = 1'bx;
        rx_if.rx_ready = 1'b1;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                k = 0;
                while (pulses < 10 && k < 12 * BIT) begin
                    tick(1);
                    k++;
                    if (clk_bps) pulses++;
                end
                tick(1);
                bps_after = bps_start;
                lat = 1;
                while (!rx_if.rx_valid && lat < 10) begin
                    tick(1);
                    lat++;
                end
            end
        join
        tick(BIT);
        total++; if (lat !== 2) begin bad++; $display("FAIL single_latency got=%0d want=2", lat); end
        total++; if (bps_after !== 1'b0) begin bad++; $display("FAIL single_bps_after_stop got=%b want=0", bps_after); end
        total++; if (got_cnt - g0 !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", got_cnt - g0); end
        total++; if (got_mem[g0 % 256] !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", got_mem[g0 % 256]); end
        total++; if (n_vcyc - v0 !== 1) begin bad++; $display("FAIL single_valid_cycles got=%0d want=1", n_vcyc - v0); end
        total++; if (n_fe - f0 !== 0) begin bad++; $display("FAIL single_fe got=%0d want=0", n_fe - f0); end
    endtask

    task automatic test_random;
        logic [7:0] exp_q [$];
        int g0;
        g0 = got_cnt;
        rx_if.rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'($urandom_range(0, 255)));
            send_byte(exp_q[i], 1'b1);
        end
        tick(BIT);
        total++; if (got_cnt - g0 !== 8) begin bad++; $display("FAIL random_count got=%0d want=8", got_cnt - g0); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got_mem[(g0 + i) % 256] !== exp_q[i]) begin
                bad++; $display("FAIL random_byte%0d got=%h want=%h", i, got_mem[(g0 + i) % 256], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int g0, o0;
        g0 = got_cnt; o0 = n_ov;
        rx_if.rx_ready = 1'b0;
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        tick(4);
        total++; if (n_ov - o0 !== 1) begin bad++; $display("FAIL b2b_overrun got=%0d want=1", n_ov - o0); end
        total++; if (rx_if.rx_data !== 8'h3C) begin bad++; $display("FAIL b2b_data_held got=%h want=3c", rx_if.rx_data); end
        total++; if (rx_if.rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_held got=%b want=1", rx_if.rx_valid); end
        rx_if.rx_ready = 1'b1;
        tick(2);
        total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_clear got=%b want=0", rx_if.rx_valid); end
        total++; if (got_cnt - g0 !== 1 || got_mem[g0 % 256] !== 8'h3C) begin
            bad++; $display("FAIL b2b_consumed got_n=%0d got=%h want_n=1 want=3c", got_cnt - g0, got_mem[g0 % 256]);
        end
        tick(BIT);
    endtask

    task automatic test_frame_err;
        int f0, v0, b0, g0;
        f0 = n_fe; v0 = n_vcyc; g0 = got_cnt;
        rx_if.rx_ready = 1'b1;
        send_byte(8'h55, 1'b0);
        b0 = n_bps;
        tick(2 * BIT);
        total++; if (n_fe - f0 !== 1) begin bad++; $display("FAIL fe_pulse got=%0d want=1", n_fe - f0); end
        total++; if (n_vcyc - v0 !== 0) begin bad++; $display("FAIL fe_no_valid got=%0d want=0", n_vcyc - v0); end
        total++; if (n_bps - b0 !== 0) begin bad++; $display("FAIL fe_no_restart got=%0d want=0", n_bps - b0); end
        rs232_rx = 1'b1;
        tick(BIT);
        send_byte(8'h12, 1'b1);
        tick(BIT);
        total++; if (got_cnt - g0 !== 1 || got_mem[g0 % 256] !== 8'h12) begin
            bad++; $display("FAIL fe_next_byte got_n=%0d got=%h want_n=1 want=12", got_cnt - g0, got_mem[g0 % 256]);
        end
    endtask

    task automatic test_glitch;
        int b0, v0, f0;
        b0 = n_bps; v0 = n_vcyc; f0 = n_fe;
        rs232_rx = 1'b0;
        tick(10);
        rs232_rx = 1'b1;
        tick(2 * BIT);
        total++; if (!(n_bps - b0 > 0 && n_bps - b0 < BIT)) begin bad++; $display("FAIL glitch_bps_cycles got=%0d want=1..%0d", n_bps - b0, BIT - 1); end
        total++; if (bps_start !== 1'b0) begin bad++; $display("FAIL glitch_bps_clear got=%b want=0", bps_start); end
        total++; if (n_vcyc - v0 !== 0 || n_fe - f0 !== 0) begin
            bad++; $display("FAIL glitch_quiet got_valid=%0d got_fe=%0d want=0/0", n_vcyc - v0, n_fe - f0);
        end
    endtask

    task automatic test_reset_midframe;
        int v0, f0, g0;
        rx_if.rx_ready = 1'b1;
        rs232_rx = 1'b0;
        tick(BIT);
        rs232_rx = 1'b1;
        tick(4 * BIT + BIT / 2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        total++; if ({bps_start, rx_if.rx_valid, frame_err, overrun} !== 4'b0 || rx_if.rx_data !== 8'h00) begin
            bad++; $display("FAIL midrst_outputs got=%b%b%b%b/%h want=0000/00", bps_start, rx_if.rx_valid, frame_err, overrun, rx_if.rx_data);
        end
        v0 = n_vcyc; f0 = n_fe; g0 = got_cnt;
        tick(5 * BIT);
        total++; if (n_vcyc - v0 !== 0 || n_fe - f0 !== 0) begin
            bad++; $display("FAIL midrst_stray got_valid=%0d got_fe=%0d want=0/0", n_vcyc - v0, n_fe - f0);
        end
        send_byte(8'h81, 1'b1);
        tick(BIT);
        total++; if (got_cnt - g0 !== 1 || got_mem[g0 % 256] !== 8'h81) begin
            bad++; $display("FAIL midrst_next got_n=%0d got=%h want_n=1 want=81", got_cnt - g0, got_mem[g0 % 256]);
        end
    endtask

    task automatic test_ready_in_delivery;
        logic [7:0] a;
        int o0, g0, k;
        a = 8'($urandom_range(0, 255));
        rx_if.rx_ready = 1'b0;
        send_byte(a, 1'b1);
        tick(BIT);
        total++; if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== a) begin
            bad++; $display("FAIL rdy_first got=%b/%h want=1/%h", rx_if.rx_valid, rx_if.rx_data, a);
        end
        o0 = n_ov; g0 = got_cnt;
        fork
            send_byte(8'h7E, 1'b1);
            begin
                k = 0;
                while (!bps_start && k < 2 * BIT) begin tick(1); k++; end
                k = 0;
                while (bps_start && k < 12 * BIT) begin tick(1); k++; end
                total++; if (bps_start !== 1'b0) begin bad++; $display("FAIL rdy_wait_stop got=%b want=0", bps_start); end
                rx_if.rx_ready = 1'b1;
                tick(1);
                rx_if.rx_ready = 1'b0;
            end
        join
        tick(BIT);
        total++; if (rx_if.rx_valid !== 1'b1) begin bad++; $display("FAIL rdy_valid got=%b want=1", rx_if.rx_valid); end
        total++; if (rx_if.rx_data !== 8'h7E) begin bad++; $display("FAIL rdy_data got=%h want=7e", rx_if.rx_data); end
        total++; if (n_ov - o0 !== 0) begin bad++; $display("FAIL rdy_overrun got=%0d want=0", n_ov - o0); end
        total++; if (got_cnt - g0 !== 1 || got_mem[g0 % 256] !== a) begin
            bad++; $display("FAIL rdy_old_taken got_n=%0d got=%h want_n=1 want=%h", got_cnt - g0, got_mem[g0 % 256], a);
        end
        rx_if.rx_ready = 1'b1;
        tick(2);
        total++; if (got_cnt - g0 !== 2 || got_mem[(g0 + 1) % 256] !== 8'h7E) begin
            bad++; $display("FAIL rdy_drain got_n=%0d got=%h want_n=2 want=7e", got_cnt - g0, got_mem[(g0 + 1) % 256]);
        end
    endtask

    initial begin
        rx_if.rx_ready = 1'b1;
        test_reset;
        test_single;
        test_random;
        test_back_to_back;
        test_frame_err;
        test_glitch;
        test_reset_midframe;
        test_ready_in_delivery;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
